sm_requantizer: RTL and testbench
=================================

# sm_requantizer

Pipelined narrowing stage for the 8-bit inner-product datapath: accepts SUM_WIDTH sign-magnitude accumulator results (sign in MSB, magnitude below), drops SHIFT fractional bits with round-half-away-from-zero, saturates to an OUT_WIDTH sign-magnitude word, and delivers it over a valid/ready handshake. It is the return path of the adder chain, converting wide sums back to the 8-bit operand format for the next layer. It also keeps a saturating count of clipped results.

## Interface
- IN_WIDTH, 19, input word width (1 sign + IN_WIDTH-1 magnitude)
- OUT_WIDTH, 8, output word width (1 sign + OUT_WIDTH-1 magnitude)
- SHIFT, 7, fractional bits dropped; 1 <= SHIFT <= IN_WIDTH-2
- iCLK  input  1  clock, rising edge
- iRSTn  input  1  asynchronous active-low reset
- iValid  input  1  upstream word valid
- oReady  output  1  block can accept a word this cycle
- iData  input  IN_WIDTH  sign-magnitude input word
- oValid  output  1  output word valid
- iReady  input  1  downstream accepts output this cycle
- oData  output  OUT_WIDTH  sign-magnitude result
- oSat  output  1  oData was clipped (qualified by oValid)
- iSatClr  input  1  synchronous clear of oSatCnt
- oSatCnt  output  8  saturating count of clipped words delivered

## Operation
- Transfer in: iValid && oReady at rising edge. Transfer out: oValid && iReady at rising edge.
- Stage 1 (on input transfer): sign1 = iData[IN_WIDTH-1]; mag = iData[IN_WIDTH-2:0]; rnd1 = (mag + 2^(SHIFT-1)) >> SHIFT, computed in IN_WIDTH bits (no carry loss); rnd1 width IN_WIDTH-SHIFT.
- Stage 2: if rnd1 > 2^(OUT_WIDTH-1)-1: magnitude = 2^(OUT_WIDTH-1)-1, sat = 1; else magnitude = rnd1, sat = 0.
- Negative zero suppressed: if final magnitude == 0, output sign = 0 (oData all zeros).
- Otherwise output sign = sign1. Input -0 (sign 1, magnitude 0) treated as 0.
- Each stage holds a valid bit v1, v2. Stage 2 loads from stage 1 when v1 && (!v2 || iReady). Stage 1 loads from input when iValid && oReady.
- oReady = !v1 || !v2 || iReady (combinational from iReady; sole combinational in->out path).
- Held stage: register contents and valid bit unchanged; no word dropped, duplicated or reordered.
- oSatCnt increments by 1 on each output transfer with oSat = 1; saturates at 255 (no wrap). iSatClr has priority: when high, oSatCnt <= 0 that cycle, even if a saturated transfer occurs.

## Timing
- Reset (iRSTn low, asynchronous): v1 = v2 = 0, oValid = 0, oData = 0, oSat = 0, oSatCnt = 0; oReady = 1 while reset asserted and after release. Reset mid-operation discards all in-flight words.
- Latency: input transfer at edge N -> oValid high after edge N+1 (word visible in cycle after second edge); 2-cycle latency.
- Throughput: one word per cycle with iReady held high.
- oData, oSat, oValid registered; stable while oValid && !iReady.
- Backpressure: with iReady low, at most 2 words buffered; oReady falls after second word accepted.
- Simultaneous output transfer and input transfer with both stages full: allowed (oReady = 1 via iReady), pipeline shifts by one.

## Test plan
- Rounding (defaults): iData magnitudes 300, 192, 191, 64, 63 with sign 0 -> oData 0x02, 0x02, 0x01, 0x01, 0x00; oSat 0; each 2 cycles after acceptance.
- Sign / negative zero: sign 1 magnitude 191 -> 0x81; sign 1 magnitude 63 -> 0x00 (not 0x80); input 0x40000 (-0) -> 0x00.
- Saturation: magnitude 16319 -> 0x7F, oSat 0; 16320 -> 0x7F, oSat 1; sign 1 magnitude 0x3FFFF -> 0xFF, oSat 1; oSatCnt = 2.
- Backpressure: stream 10 words with iReady toggling 1,0,0,1 repeating -> all 10 outputs in order, unchanged while stalled, oReady low only when v1 && v2 && !iReady.
- Counter limits: 300 saturated outputs -> oSatCnt 255; iSatClr asserted coincident with saturated transfer -> oSatCnt 0 next cycle.
- Reset mid-stream: assert iRSTn low with both stages full -> oValid, oData, oSat, oSatCnt 0 immediately; after release first new input appears 2 cycles after acceptance with no stale word.

Source files
------------

// File: rtl/sm_requantizer.sv
// Two-stage sign-magnitude narrowing stage: round-half-away-from-zero on the
// magnitude, saturate to OUT_WIDTH, valid/ready handshake, clip counter.
module sm_requantizer #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 7
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [IN_WIDTH-1:0]  iData,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [OUT_WIDTH-1:0] oData,
    output logic                 oSat,
    input  logic                 iSatClr,
    output logic [7:0]           oSatCnt
);
    localparam int STAGES = 2;
    localparam int RW     = IN_WIDTH - SHIFT;
    localparam int MW     = OUT_WIDTH - 1;
    localparam logic [IN_WIDTH-1:0] HALF = {{(IN_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [31:0]         MAXM = (32'd1 << MW) - 32'd1;

    // vld_pipe[1] = stage 1 (rounded), vld_pipe[2] = stage 2 (output register)
    logic [STAGES:1] vld_pipe;
    logic            s1_sign;
    logic [RW-1:0]   s1_rnd;

    logic                ld1, ld2, out_xfer;
    logic [IN_WIDTH-1:0] sum;
    logic [RW-1:0]       rnd;
    logic                sat;
    logic [MW-1:0]       mag;
    logic [OUT_WIDTH-1:0] word;

    assign oReady   = !vld_pipe[1] || !vld_pipe[2] || iReady;
    assign ld1      = iValid && oReady;
    assign ld2      = vld_pipe[1] && (!vld_pipe[2] || iReady);
    assign out_xfer = vld_pipe[2] && iReady;
    assign oValid   = vld_pipe[2];

    // Magnitude is zero-extended to IN_WIDTH so the rounding carry is kept.
    assign sum = {1'b0, iData[IN_WIDTH-2:0]} + HALF;
    assign rnd = sum[IN_WIDTH-1:SHIFT];

    always_comb begin
        sat  = 32'(s1_rnd) > MAXM;
        mag  = sat ? {MW{1'b1}} : MW'(s1_rnd);
        // A zero magnitude always leaves as +0, never -0.
        word = {s1_sign && (mag != '0), mag};
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            vld_pipe <= '0;
            s1_sign  <= 1'b0;
            s1_rnd   <= '0;
            oData    <= '0;
            oSat     <= 1'b0;
        end else begin
            if (ld1) begin
                vld_pipe[1] <= 1'b1;
                s1_sign     <= iData[IN_WIDTH-1];
                s1_rnd      <= rnd;
            end else if (ld2) begin
                vld_pipe[1] <= 1'b0;
            end
            if (ld2) begin
                vld_pipe[2] <= 1'b1;
                oData       <= word;
                oSat        <= sat;
            end else if (out_xfer) begin
                vld_pipe[2] <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            oSatCnt <= '0;
        else if (iSatClr)
            oSatCnt <= '0;
        else if (out_xfer && oSat && oSatCnt != 8'hFF)
            oSatCnt <= oSatCnt + 8'd1;
    end
endmodule

// File: tb/tb_sm_requantizer.sv
// Bench for sm_requantizer: directed vector table, randomized backpressure
// streams against an arithmetic model, counter limits and mid-stream reset.
module tb_sm_requantizer;
    localparam int IW = 19, OW = 8, SH = 7;

    logic          iCLK = 1'b0, iRSTn = 1'b0;
    logic          iValid = 1'b0, iReady = 1'b1, iSatClr = 1'b0;
    logic [IW-1:0] iData = '0;
    logic          oReady, oValid, oSat;
    logic [OW-1:0] oData;
    logic [7:0]    oSatCnt;

    sm_requantizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iValid(iValid), .oReady(oReady),
        .iData(iData), .oValid(oValid), .iReady(iReady), .oData(oData),
        .oSat(oSat), .iSatClr(iSatClr), .oSatCnt(oSatCnt));

    always #5 iCLK = ~iCLK;

    int n_vec = 0, n_bad = 0;
    int mcnt = 0;

    typedef struct {
        logic [IW-1:0] d;
        logic [OW-1:0] o;
        logic          s;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the magnitude.
    function automatic void ref_q(input logic [IW-1:0] d, output logic [OW-1:0] o, output logic s);
        longint m, r;
        m = longint'(d[IW-2:0]);
        r = (m + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
        s = r > (longint'(1) << (OW - 1)) - 1;
        if (s) r = (longint'(1) << (OW - 1)) - 1;
        o = OW'(r);
        if (r != 0 && d[IW-1]) o[OW-1] = 1'b1;
    endfunction

    task automatic apply_one(input vec_t v, input string name);
        @(negedge iCLK);
        iReady = 1'b1; iValid = 1'b1; iData = v.d;
        @(negedge iCLK);
        iValid = 1'b0;
        chk({name, "_lat1_valid"}, 32'(oValid), 32'd0);
        @(negedge iCLK);
        chk({name, "_out"}, {23'd0, oValid, oSat, oData}, {23'd0, 1'b1, v.s, v.o});
    endtask

    task automatic run_stream(input int nwords, input bit pattern, input bit rnd_clr, input bit sat_only);
        logic [OW-1:0] qo[$];
        logic          qs[$];
        logic [OW-1:0] eo, hold_d;
        logic          es, hold_s;
        bit            stalled, in_x, out_x;
        int            sent, cyc;
        stalled = 0; sent = 0; cyc = 0; hold_d = '0; hold_s = 0;
        while ((sent < nwords || qo.size() > 0) && cyc < 5000) begin
            @(negedge iCLK);
            cyc++;
            if (pattern) iReady = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            else         iReady = $urandom_range(0, 3) != 0;
            iValid = (sent < nwords) && (pattern || sat_only || $urandom_range(0, 3) != 0);
            if (sat_only)
                iData = {1'($urandom_range(0, 1)), 18'h3FFFF - 18'($urandom_range(0, 1000))};
            else if ($urandom_range(0, 1) == 0)
                iData = {1'($urandom_range(0, 1)), 18'($urandom_range(0, 20000))};
            else
                iData = IW'($urandom);
            iSatClr = rnd_clr && ($urandom_range(0, 15) == 0);
            #1;
            chk("oready", 32'(oReady), 32'(!(qo.size() == 2 && !iReady)));
            chk("satcnt", 32'(oSatCnt), 32'(mcnt));
            if (stalled)
                chk("stall_hold", {23'd0, oValid, oSat, oData}, {23'd0, 1'b1, hold_s, hold_d});
            out_x = oValid && iReady;
            in_x  = iValid && oReady;
            if (oValid && qo.size() == 0) chk("spurious_valid", 32'(oValid), 32'd0);
            if (out_x && qo.size() > 0) begin
                eo = qo.pop_front(); es = qs.pop_front();
                chk("stream_out", {23'd0, oSat, oData}, {23'd0, es, eo});
                if (iSatClr) mcnt = 0;
                else if (es && mcnt < 255) mcnt++;
            end else if (iSatClr) begin
                mcnt = 0;
            end
            if (in_x) begin
                ref_q(iData, eo, es);
                qo.push_back(eo); qs.push_back(es);
                sent++;
            end
            stalled = oValid && !iReady;
            hold_d = oData; hold_s = oSat;
        end
        if (cyc >= 5000) chk("stream_timeout", 32'(cyc), 32'd0);
        @(negedge iCLK);
        iValid = 1'b0; iSatClr = 1'b0; iReady = 1'b1;
        chk("satcnt_end", 32'(oSatCnt), 32'(mcnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{19'd300, 8'h02, 1'b0};
        tbl[1]  = '{19'd192, 8'h02, 1'b0};
        tbl[2]  = '{19'd191, 8'h01, 1'b0};
        tbl[3]  = '{19'd64,  8'h01, 1'b0};
        tbl[4]  = '{19'd63,  8'h00, 1'b0};
        tbl[5]  = '{19'h40000 | 19'd191, 8'h81, 1'b0};
        tbl[6]  = '{19'h40000 | 19'd63,  8'h00, 1'b0};
        tbl[7]  = '{19'h40000, 8'h00, 1'b0};
        tbl[8]  = '{19'd16319, 8'h7F, 1'b0};
        tbl[9]  = '{19'd16320, 8'h7F, 1'b1};
        tbl[10] = '{19'h7FFFF, 8'hFF, 1'b1};

        // Reset state
        #1;
        chk("rst_state", {14'd0, oValid, oSat, oData, oSatCnt}, 32'd0);
        chk("rst_oready", 32'(oReady), 32'd1);
        @(negedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b1;

        foreach (tbl[i]) apply_one(tbl[i], $sformatf("vec%0d", i));
        @(negedge iCLK);
        chk("satcnt_tbl", 32'(oSatCnt), 32'd2);
        mcnt = 2;

        // 10 words with iReady pattern 1,0,0,1 then a random mix with clears
        run_stream(10, 1'b1, 1'b0, 1'b0);
        run_stream(200, 1'b0, 1'b1, 1'b0);

        // Counter cap
        @(negedge iCLK); iSatClr = 1'b1;
        @(negedge iCLK); iSatClr = 1'b0; mcnt = 0;
        chk("satcnt_clr", 32'(oSatCnt), 32'd0);
        run_stream(300, 1'b0, 1'b0, 1'b1);
        chk("satcnt_cap", 32'(oSatCnt), 32'd255);

        // Clear coincident with a saturated output transfer
        @(negedge iCLK); iReady = 1'b1; iValid = 1'b1; iData = 19'd16320;
        @(negedge iCLK); iValid = 1'b0;
        @(negedge iCLK); iSatClr = 1'b1;
        #1 chk("clr_coinc_valid", {30'd0, oValid, oSat}, 32'd3);
        @(negedge iCLK); iSatClr = 1'b0;
        chk("clr_coinc_cnt", 32'(oSatCnt), 32'd0);

        // Reset with both stages full
        apply_one(tbl[9], "pre_rst");
        @(negedge iCLK);
        chk("pre_rst_cnt", 32'(oSatCnt), 32'd1);
        iReady = 1'b0; iValid = 1'b1; iData = 19'd16320;
        @(negedge iCLK); iData = 19'd300;
        @(negedge iCLK); iValid = 1'b0;
        #1 chk("full_oready", {30'd0, oReady, oValid}, 32'd1);
        iRSTn = 1'b0;
        #1;
        chk("midrst_out", {14'd0, oValid, oSat, oData, oSatCnt}, 32'd0);
        chk("midrst_oready", 32'(oReady), 32'd1);
        @(negedge iCLK); iRSTn = 1'b1; iReady = 1'b1;
        apply_one(tbl[5], "post_rst");
        @(negedge iCLK);
        chk("post_rst_nostale", 32'(oValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
